// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one pipelined DSP multiplier
// among NUM_REQ requesters, with one result register per requester.
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [NUM_REQ*WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0]         mul_in0,
  output logic [WIDTH-1:0]         mul_in1,
  output logic                     mul_valid_in,
  input  logic [WIDTH-1:0]         mul_out,
  output logic                     idle
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ-1);

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      grant;
  logic [IW-1:0]      ptr_nxt;
  logic               grant_any;
  logic [IW:0]        scan;
  logic [WIDTH-1:0]   res [NUM_REQ];
  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_id [LATENCY];

  // One outstanding op per requester keeps its result slot free.
  assign elig = req_valid & ~busy & {NUM_REQ{reset_n}};

  always_comb begin
    grant_any = 1'b0;
    grant     = '0;
    scan      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan = {1'b0, ptr} + (IW+1)'(j);
      if (scan >= NR) scan = scan - NR;
      if (!grant_any && elig[scan[IW-1:0]]) begin
        grant_any = 1'b1;
        grant     = scan[IW-1:0];
      end
    end
  end

  assign ptr_nxt = (grant == LAST) ? '0 : grant + IW'(1);

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant] = 1'b1;
  end

  assign mul_valid_in = grant_any;
  assign mul_in0 = grant_any ? req_in0[grant*WIDTH +: WIDTH] : '0;
  assign mul_in1 = grant_any ? req_in1[grant*WIDTH +: WIDTH] : '0;

  always_comb begin
    resp_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_data[i*WIDTH +: WIDTH] = res[i];
  end

  assign idle = ~|busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      resp_valid <= '0;
      ptr        <= '0;
      tag_v      <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
      for (int i = 0; i < NUM_REQ; i++) res[i] <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
          busy[i]       <= 1'b0;
        end
      end
      if (grant_any) begin
        busy[grant] <= 1'b1;
        ptr         <= ptr_nxt;
      end
      // Last tag stage lines up with the product on mul_out.
      if (tag_v[LATENCY-1]) begin
        res[tag_id[LATENCY-1]]        <= mul_out;
        resp_valid[tag_id[LATENCY-1]] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed and random stimulus against a cycle-count
// reference model, with a behavioural pipelined multiplier.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] resp_ready = '0;
  logic [N*W-1:0] req_in0 = '0;
  logic [N*W-1:0] req_in1 = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] resp_valid;
  logic [N*W-1:0] resp_data;
  logic [W-1:0] mul_in0;
  logic [W-1:0] mul_in1;
  logic [W-1:0] mul_out;
  logic mul_valid_in;
  logic idle;
  logic [W-1:0] mp [L];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int m_ptr = 0;
  bit m_out [N];
  int m_due [N];
  logic [W-1:0] m_prod [N];
  logic [W-1:0] m_last [N];

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_in0(req_in0),
    .req_in1(req_in1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .mul_in0(mul_in0),
    .mul_in1(mul_in1),
    .mul_valid_in(mul_valid_in),
    .mul_out(mul_out),
    .idle(idle)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    mp[0] <= mul_valid_in ? mul_in0 * mul_in1 : '0;
    for (int s = 1; s < L; s++) mp[s] <= mp[s-1];
  end
  assign mul_out = mp[L-1];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_out[i]  = 1'b0;
      m_due[i]  = 0;
      m_prod[i] = '0;
      m_last[i] = '0;
    end
  endtask

  function automatic int exp_grant();
    for (int j = 0; j < N; j++) begin
      int k;
      k = (m_ptr + j) % N;
      if (req_valid[k] && !m_out[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  // Called just after a negedge with inputs applied; returns at next negedge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic [31:0] full;
    bit any;
    if (!reset_n) model_clear();
    #1;
    g = reset_n ? exp_grant() : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    check("mul_valid_in", mul_valid_in, g >= 0);
    if (g >= 0) begin
      check("mul_in0", mul_in0, req_in0[g*W +: W]);
      check("mul_in1", mul_in1, req_in1[g*W +: W]);
    end else begin
      check("mul_in0_zero", mul_in0, '0);
      check("mul_in1_zero", mul_in1, '0);
    end
    any = 1'b0;
    ev = '0;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_out[i] && (cyc >= m_due[i]);
      any = any | m_out[i];
    end
    check("resp_valid", resp_valid, ev);
    for (int i = 0; i < N; i++)
      check("resp_data", resp_data[i*W +: W], ev[i] ? m_prod[i] : m_last[i]);
    check("idle", idle, !any);
    @(posedge clock);
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (ev[i] && resp_ready[i]) begin
          m_out[i]  = 1'b0;
          m_last[i] = m_prod[i];
        end
      end
      if (g >= 0) begin
        full = 32'(req_in0[g*W +: W]) * 32'(req_in1[g*W +: W]);
        m_out[g]  = 1'b1;
        m_due[g]  = cyc + L + 1;
        m_prod[g] = full[W-1:0];
        m_ptr     = (g + 1) % N;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    model_clear();
    req_valid = '1;
    @(negedge clock);
    step();
    step();
    reset_n = 1'b1;
    req_valid = '0;
    step();

    set_ops(2, 16'd3, 16'd7);
    req_valid = 4'b0100;
    #1 check("single_grant", req_ready, 4'b0100);
    step();
    repeat (2) step();
    #1 check("single_rv", resp_valid, 4'b0100);
    repeat (5) begin
      #1 check("hold_data", resp_data[2*W +: W], 16'd21);
      check("hold_ready", req_ready, 4'b0000);
      step();
    end
    resp_ready = 4'b0100;
    step();
    req_valid = '0;
    resp_ready = '1;
    step();

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", req_ready, N'(1) << (k % N));
      if (k > 0) check("rr_idle", idle, 1'b0);
      step();
    end
    req_valid = '0;
    repeat (5) step();

    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    #1 check("wrap_g3", req_ready, 4'b1000);
    step();
    #1 check("wrap_g0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (5) step();
    req_valid = 4'b0010;
    #1 check("wrap_g1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0111;
    #1 check("wrap_ptr2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    repeat (5) step();

    resp_ready = '0;
    set_ops(0, 16'hFFFF, 16'h0002);
    set_ops(1, 16'h0100, 16'h0100);
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    repeat (3) step();
    #1 check("trunc0", resp_data[W-1:0], 16'hFFFE);
    check("trunc1", resp_data[2*W-1:W], 16'h0000);
    resp_ready = '1;
    repeat (2) step();

    resp_ready = '0;
    set_ops(0, 16'd11, 16'd13);
    set_ops(1, 16'd17, 16'd19);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    resp_ready = 4'b0010;
    step();
    resp_ready = '0;
    req_valid = 4'b0011;
    #1 check("sim_rv", resp_valid, 4'b0001);
    check("sim_idle", idle, 1'b0);
    check("sim_busy", req_ready, 4'b0010);
    step();
    req_valid = '0;
    resp_ready = '1;
    repeat (5) step();

    for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) begin
      #1 check("rst_rv", resp_valid, '0);
      check("rst_idle", idle, 1'b1);
      step();
    end
    set_ops(2, 16'd5, 16'd9);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (2) step();
    #1 check("post_rst", resp_data[2*W +: W], 16'd45);
    step();

    for (int n = 0; n < 3000; n++) begin
      req_valid = N'($urandom);
      resp_ready = N'($urandom) | N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_ops(i, 16'hFFFF, W'($urandom));
        else set_ops(i, W'($urandom), W'($urandom));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter that shares one pipelined 16x16=16 DSP multiplier among `NUM_REQ` requesters. It accepts operand pairs over valid/ready handshakes and issues at most one multiply per cycle. It tracks each in-flight operation with a requester tag through a shift pipeline matched to the multiplier latency, captures each product into that requester's one-entry result register, and returns it over a valid/ready response handshake. It sits between the core execution units and the single `MultiplierDsp48` instance, which has no stall input.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand/product width; must match the multiplier
- `LATENCY`, 2, multiplier latency in cycles, from `mul_valid_in` to the product on `mul_out`
- `clock` in 1: single clock; all state updates on posedge
- `reset_n` in 1: reset, asynchronous, active-low
- `req_valid` in NUM_REQ: per-requester operand valid
- `req_ready` out NUM_REQ: per-requester grant, one-hot or zero
- `req_in0` in NUM_REQ*WIDTH: operand 0, requester i at bits [i*WIDTH +: WIDTH]
- `req_in1` in NUM_REQ*WIDTH: operand 1, same packing
- `resp_valid` out NUM_REQ: product held for requester i
- `resp_ready` in NUM_REQ: requester i accepts its product
- `resp_data` out NUM_REQ*WIDTH: held products, same packing
- `mul_in0` out WIDTH: to multiplier `in0`
- `mul_in1` out WIDTH: to multiplier `in1`
- `mul_valid_in` out 1: to multiplier `valid_in`; high on issue cycles
- `mul_out` in WIDTH: from multiplier `out`
- `idle` out 1: no operation in flight and no product held

## Operation
- State per requester: `busy[i]` and result register `res[i]`/`resp_valid[i]`. Shared state: round-robin pointer `ptr` (0..NUM_REQ-1) and a tag pipeline of LATENCY stages, each stage {valid, id}.
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`. This limits each requester to one outstanding operation, so its result slot is always free when its product arrives.
- Arbitration is combinational. Grant goes to the first eligible index scanning ptr, ptr+1, … with wrap-around mod NUM_REQ. `req_ready[grant]=1`, all other bits 0. Without eligibility `req_ready=0`.
- On a grant:
  - `mul_in0`/`mul_in1` take the granted operands and `mul_valid_in=1`.
  - Tag stage 0 captures {1, grant}.
  - `busy[grant]` is set.
  - `ptr` takes (grant+1) mod NUM_REQ.
- With no grant: `mul_in0=mul_in1=0`, `mul_valid_in=0`, tag stage 0 captures {0, x}, and `ptr` holds.
- `req_ready` does not depend on `resp_ready` in the same cycle. No combinational path exists from `resp_*` to `req_*`.
- Tag pipeline shifts every cycle and never stalls.
- Capture: when the last stage (LATENCY-1) is valid with id k, then at the clock edge `res[k] <= mul_out` and `resp_valid[k] <= 1`. That stage aligns with `mul_out` being valid.
- Response: `resp_valid[k] & resp_ready[k]` at an edge clears `resp_valid[k]` and `busy[k]`. `resp_data` holds its value after the handshake.
- Simultaneous events:
  - Capture and response handshake for the same k cannot coincide, because k has one outstanding operation.
  - Captures and handshakes for different requesters in the same cycle are independent.
- `idle = ~|busy`.
- Products are the low WIDTH bits of the unsigned product, computed by the multiplier. The arbiter does no arithmetic.

## Timing
- Issue in cycle t: `req_ready[i]`, `mul_valid_in` and operands are combinational in cycle t.
- `mul_out` is valid in cycle t+LATENCY. `resp_valid[i]` rises in cycle t+LATENCY+1.
- Earliest re-issue for the same requester is the cycle after its response handshake. `busy` is registered.
- Aggregate throughput is 1 issue/cycle when at least LATENCY+2 requesters have work. A single requester gets at most 1 issue per LATENCY+2 cycles when `resp_ready` is held high.
- Reset values (async, `reset_n=0`):
  - Outputs: `req_ready=0`, `resp_valid=0`, `resp_data=0`, `mul_in0=mul_in1=0`, `mul_valid_in=0`, `idle=1`.
  - Internal state: `ptr=0`, all tag stages invalid, `busy=0`.
  - Outputs that are combinational from `req_valid` must be gated to 0 while `reset_n=0`.
- Reset mid-operation: in-flight tags are discarded. Multiplier outputs that emerge after deassertion are ignored because no valid tag matches them. No `resp_valid` pulse comes from pre-reset issues.
- First grant is possible in the first cycle with `reset_n=1`.

## Test plan
- **Single requester:** reset, then `req_valid[2]=1` with in0=3, in1=7 at t. Expect `req_ready=4'b0100` at t, `mul_valid_in=1`, `resp_valid[2]=1` at t+3, `resp_data[2]=21`. Hold `resp_ready[2]=0` for 5 cycles: data stable and `req_ready[2]=0` throughout.
- **Round-robin fairness:** all 4 `req_valid=1` continuously, `resp_ready=1111`. Grants go 0,1,2,3 in cycles t..t+3. Requester 0 re-issues no earlier than t+4; issue rate is 1/cycle; `idle=0`.
- **Pointer wrap:** ptr=3, requesters 0 and 3 eligible. Grant 3, then grant 0 next cycle. With only requester 1 eligible at ptr=2, grant 1 and ptr becomes 2.
- **Width truncation:** in0=16'hFFFF, in1=16'h0002. Expect `resp_data=16'hFFFE`. in0=16'h0100, in1=16'h0100: expect 16'h0000.
- **Simultaneous capture and drain:** requester 1 is accepting its result while requester 0's product is captured in the same cycle. Both register correctly: `resp_valid=4'b0001`, `busy=4'b0001`.
- **Reset mid-operation:** issue for requesters 0 and 1, then assert `reset_n=0` for 1 cycle at t+1. `resp_valid` stays 0 for 5 cycles afterwards, `idle=1`, and a new issue completes normally.
